// File: rtl/comparator.sv
// Branch-condition evaluator: tests the ALU status flags against a condition code.
// Produces a registered branch-taken strobe, gated by the control unit's branch enable.
module comparator (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] condicao,
    input  logic [5:0] flags,
    input  logic       control,
    output logic       salto
);

    logic w_cond_true;
    logic w_flag_xor;
    logic w_taken;
    logic r_salto;

    assign w_flag_xor = flags[2] ^ flags[3];

    // Unknown codes fall to "not taken", so X/Z on condicao never asserts salto.
    always_comb begin
        w_cond_true = 1'b0;
        case (condicao)
            4'b0000: w_cond_true = flags[0];
            4'b0001: w_cond_true = flags[1];
            4'b0010: w_cond_true = flags[2];
            4'b0011: w_cond_true = flags[3];
            4'b0100: w_cond_true = flags[4];
            4'b0101: w_cond_true = flags[5];
            4'b0110: w_cond_true = 1'b1;
            4'b0111: w_cond_true = 1'b0;
            4'b1000: w_cond_true = ~flags[0];
            4'b1001: w_cond_true = ~flags[1];
            4'b1010: w_cond_true = ~flags[2];
            4'b1011: w_cond_true = ~flags[3];
            4'b1100: w_cond_true = ~flags[4];
            4'b1101: w_cond_true = ~flags[5];
            4'b1110: w_cond_true = w_flag_xor;
            4'b1111: w_cond_true = flags[0] | w_flag_xor;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_taken = control & w_cond_true;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_salto <= 1'b0;
        end else begin
            r_salto <= w_taken;
        end
    end

    assign salto = r_salto;

endmodule

// File: tb/tb_comparator.sv
// Directed-vector bench for the branch-condition comparator.
// Inputs change on the falling edge; salto is checked 1 time unit after each rising edge.
module tb_comparator;

    logic       clk;
    logic       reset;
    logic [3:0] condicao;
    logic [5:0] flags;
    logic       control;
    logic       salto;

    int n_checks;
    int n_fail;

    comparator dut (
        .clk      (clk),
        .reset    (reset),
        .condicao (condicao),
        .flags    (flags),
        .control  (control),
        .salto    (salto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: salto=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the registered result after the edge.
    task automatic step(
        input logic       rst,
        input logic       ctl,
        input logic [3:0] cc,
        input logic [5:0] fl,
        input logic       exp,
        input string      tag
    );
        @(negedge clk);
        reset    = rst;
        control  = ctl;
        condicao = cc;
        flags    = fl;
        @(posedge clk);
        #1;
        check(tag, salto, exp);
    endtask

    // Hand-computed expectations, indexed by condition code 0..5.
    logic exp_dir_a [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_dir_b [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_neg_a [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        control  = 1'b1;
        condicao = 4'b0110;
        flags    = 6'b000000;

        // Reset wins over an always-true condition with branch enabled.
        step(1'b1, 1'b1, 4'b0110, 6'b000000, 1'b0, "reset_clear");
        step(1'b1, 1'b1, 4'b0110, 6'b111111, 1'b0, "reset_prio");
        step(1'b0, 1'b1, 4'b0110, 6'b000000, 1'b1, "reset_release");

        // Output holds between edges.
        @(negedge clk);
        check("hold_mid_cycle", salto, 1'b1);

        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 4'(i), 6'b010101, exp_dir_a[i],
                 $sformatf("direct_010101_c%0d", i));

        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 4'(i), 6'b111000, exp_dir_b[i],
                 $sformatf("direct_111000_c%0d", i));

        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 4'(8 + i), 6'b010101, exp_neg_a[i],
                 $sformatf("negated_010101_c%0d", 8 + i));

        step(1'b0, 1'b1, 4'b0111, 6'b010101, 1'b0, "never");
        step(1'b0, 1'b1, 4'b0110, 6'b010101, 1'b1, "always");

        step(1'b0, 1'b1, 4'b1110, 6'b000100, 1'b1, "xor_f2_only");
        step(1'b0, 1'b1, 4'b1111, 6'b000100, 1'b1, "or_xor_f2_only");
        step(1'b0, 1'b1, 4'b1110, 6'b001100, 1'b0, "xor_f2_f3");
        step(1'b0, 1'b1, 4'b1111, 6'b001100, 1'b0, "or_xor_f2_f3");
        step(1'b0, 1'b1, 4'b1111, 6'b001101, 1'b1, "or_xor_f0");
        step(1'b0, 1'b1, 4'b1110, 6'b001000, 1'b1, "xor_f3_only");
        step(1'b0, 1'b1, 4'b1111, 6'b000001, 1'b1, "or_f0_only");
        step(1'b0, 1'b1, 4'b1111, 6'b000000, 1'b0, "or_xor_none");

        // Branch enable low masks every condition.
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 4'(i), 6'b111111, 1'b0,
                 $sformatf("ctl0_c%0d", i));

        step(1'b0, 1'b1, 4'b0000, 6'b111111, 1'b1, "ctl_toggle_on");
        step(1'b0, 1'b0, 4'b0000, 6'b111111, 1'b0, "ctl_toggle_off");

        // Reset asserted mid-stream, then released.
        step(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0, "midstream_reset");
        step(1'b0, 1'b1, 4'b0000, 6'b111111, 1'b1, "midstream_release");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: salto=%b expected=finish", salto);
        $fatal(1, "timeout");
    end

endmodule
